// File: rtl/i2c_target.sv
// I2C target (slave) with an 8-bit register pointer, running on a system clock.
// The bus lines are synchronized and edge-detected. Clock stretching is not supported.
//
// Ports:
//   clk, rst   system clock; synchronous active-high reset
//   scl, sda   I2C lines (asynchronous inputs)
//   sda_out    open-drain SDA drive: 0 pulls low, 1 releases
//   reg_addr   register pointer presented to the bank
//   reg_wdata  write data byte
//   reg_wr     one-cycle write strobe
//   reg_rd     one-cycle read strobe
//   reg_rdata  read data, valid the cycle after reg_rd
//   busy       high from address match until STOP
//   stop_det   one-cycle pulse on every STOP
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_out,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_prev, sda_prev;
  logic       scl_s, sda_s;
  logic       scl_pos, scl_neg, sda_pos, sda_neg;
  logic       start_ev, stop_ev;
  logic [3:0] bit_cnt;
  logic       bit_open;   // an scl_pos has been seen in the current bit
  logic [7:0] shreg;
  logic [7:0] ptr;
  logic [7:0] rd_buf;
  logic       rw;
  logic       mst_ack;
  logic       rd_d;
  logic       sda_nxt;
  logic       byte_end, ack_end, addr_match;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_pos  = scl_s & ~scl_prev;
  assign scl_neg  = ~scl_s & scl_prev;
  assign sda_pos  = sda_s & ~sda_prev;
  assign sda_neg  = ~sda_s & sda_prev;
  assign start_ev = sda_neg & scl_s;
  assign stop_ev  = sda_pos & scl_s;

  // The scl_neg that directly follows START carries no bit, so a bit only
  // counts once its rising edge was observed.
  assign byte_end   = scl_neg && bit_open && (bit_cnt == 4'd7);
  assign ack_end    = scl_neg && bit_open && (bit_cnt == 4'd8);
  assign addr_match = (shreg[7:1] == DEV_ADDR);
  assign reg_addr   = ptr;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    sda_nxt = sda_out;
    if (stop_ev) begin
      state_d = IDLE;
      sda_nxt = 1'b1;
    end else if (start_ev) begin
      state_d = ADDR;
      sda_nxt = 1'b1;
    end else begin
      case (state_q)
        ADDR: if (byte_end) begin
          if (addr_match) begin
            state_d = ADDR_ACK;
            sda_nxt = 1'b0;
          end else begin
            state_d = IGNORE;
            sda_nxt = 1'b1;
          end
        end
        ADDR_ACK: if (ack_end) begin
          if (rw) begin
            state_d = RDATA;
            sda_nxt = rd_buf[7];
          end else begin
            state_d = PTR;
            sda_nxt = 1'b1;
          end
        end
        PTR: if (byte_end) begin
          state_d = PTR_ACK;
          sda_nxt = 1'b0;
        end
        PTR_ACK: if (ack_end) begin
          state_d = WDATA;
          sda_nxt = 1'b1;
        end
        WDATA: if (byte_end) begin
          state_d = WDATA_ACK;
          sda_nxt = 1'b0;
        end
        WDATA_ACK: if (ack_end) begin
          state_d = WDATA;
          sda_nxt = 1'b1;
        end
        RDATA: begin
          if (byte_end) begin
            state_d = RDATA_ACK;
            sda_nxt = 1'b1;
          end else if (scl_neg && bit_open) begin
            sda_nxt = shreg[6];
          end
        end
        RDATA_ACK: if (ack_end) begin
          if (mst_ack) begin
            state_d = RDATA;
            sda_nxt = rd_buf[7];
          end else begin
            state_d = IGNORE;
            sda_nxt = 1'b1;
          end
        end
        default: sda_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_out   <= 1'b1;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      busy      <= 1'b0;
      stop_det  <= 1'b0;
      ptr       <= '0;
      bit_cnt   <= '0;
      bit_open  <= 1'b0;
      shreg     <= '0;
      rd_buf    <= '0;
      rw        <= 1'b0;
      mst_ack   <= 1'b0;
      rd_d      <= 1'b0;
    end else begin
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      stop_det <= 1'b0;
      rd_d     <= reg_rd;
      sda_out  <= sda_nxt;
      if (rd_d) rd_buf <= reg_rdata;
      if (reg_wr) ptr <= ptr + 8'd1;

      if (stop_ev) begin
        stop_det <= 1'b1;
        busy     <= 1'b0;
        bit_cnt  <= '0;
        bit_open <= 1'b0;
      end else if (start_ev) begin
        bit_cnt  <= '0;
        bit_open <= 1'b0;
      end else if (state_q != IDLE && state_q != IGNORE) begin
        if (scl_pos) begin
          bit_open <= 1'b1;
          if (!bit_cnt[3] && (state_q == ADDR || state_q == PTR || state_q == WDATA))
            shreg <= {shreg[6:0], sda_s};
          if (state_q == WDATA && bit_cnt == 4'd7) begin
            reg_wr    <= 1'b1;
            reg_wdata <= {shreg[6:0], sda_s};
          end
          // Pointer bump and read strobe share an edge so reg_addr already
          // shows the new pointer while reg_rd is high.
          if (state_q == RDATA_ACK) begin
            mst_ack <= ~sda_s;
            if (!sda_s) begin
              ptr    <= ptr + 8'd1;
              reg_rd <= 1'b1;
            end
          end
        end else if (scl_neg && bit_open) begin
          bit_open <= 1'b0;
          bit_cnt  <= (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
          case (state_q)
            ADDR: if (bit_cnt == 4'd7 && addr_match) begin
              busy   <= 1'b1;
              rw     <= shreg[0];
              reg_rd <= shreg[0];
            end
            ADDR_ACK:  if (bit_cnt == 4'd8 && rw) shreg <= rd_buf;
            PTR:       if (bit_cnt == 4'd7) ptr <= shreg;
            RDATA:     if (bit_cnt < 4'd7) shreg <= {shreg[6:0], 1'b0};
            RDATA_ACK: if (bit_cnt == 4'd8 && mst_ack) shreg <= rd_buf;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level master driver, register bank, reference model
// (pointer + bank image) feeding expectation queues, and monitors comparing them.
module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_out;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_wr, reg_rd, busy, stop_det;

  assign sda_line = m_sda & sda_out;

  i2c_target #(.DEV_ADDR(7'h42)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda_line), .sda_out(sda_out),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .busy(busy), .stop_det(stop_det)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // register bank seen by the DUT
  logic [7:0] bank [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_addr = '0, pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) bank[pl_addr] <= pl_data;
    else if (reg_wr) bank[reg_addr] <= reg_wdata;
    if (reg_rd) reg_rdata <= bank[reg_addr];
  end

  // reference model
  logic [7:0]  mbank [256];
  logic [7:0]  mptr = '0;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic        exp_sda [$];
  int          exp_stop = 0;
  int          stop_cnt = 0;
  event        bit_ev;
  logic [7:0]  wbuf [4];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // strobe monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: got addr %0h data %0h, none expected", reg_addr, reg_wdata);
        end else chk("reg_wr", {reg_addr, reg_wdata}, exp_wr.pop_front());
      end
      if (reg_rd) begin
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got addr %0h, none expected", reg_addr);
        end else chk("reg_rd_addr", {8'h00, reg_addr}, {8'h00, exp_rd.pop_front()});
      end
      if (stop_det) stop_cnt++;
    end
  end

  // bus monitor: checks sda_out in the middle of every data/ack bit
  initial begin
    forever begin
      @(bit_ev);
      if (exp_sda.size() == 0) begin
        total++; bad++;
        $display("FAIL sda_slot: got %0b, no expectation", sda_out);
      end else chk("sda_out", {15'h0, sda_out}, {15'h0, exp_sda.pop_front()});
    end
  end

  task automatic hp();
    repeat (8) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, input logic e);
    m_sda = b;
    hp();
    scl = 1'b1;
    repeat (4) @(negedge clk);
    exp_sda.push_back(e);
    -> bit_ev;
    repeat (4) @(negedge clk);
    scl = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_start();
    m_sda = 1'b1; hp();
    scl = 1'b1;   hp();
    m_sda = 1'b0; hp();
    scl = 1'b0;   hp();
  endtask

  task automatic do_stop();
    m_sda = 1'b0; hp();
    scl = 1'b1;   hp();
    m_sda = 1'b1; hp();
    exp_stop++;
  endtask

  // ack=1: target is expected to pull SDA low in the ninth bit
  task automatic send_byte(input logic [7:0] d, input logic ack);
    for (int j = 7; j >= 0; j--) clk_bit(d[j], 1'b1);
    clk_bit(1'b1, ~ack);
  endtask

  task automatic write_seq(input logic [7:0] p, input int unsigned n);
    logic [7:0] d;
    do_start();
    send_byte(8'h84, 1'b1);
    chk("busy_on", {15'h0, busy}, 16'h1);
    send_byte(p, 1'b1);
    mptr = p;
    for (int unsigned i = 0; i < n; i++) begin
      d = wbuf[i];
      exp_wr.push_back({mptr, d});
      mbank[mptr] = d;
      send_byte(d, 1'b1);
      mptr = mptr + 8'd1;
    end
    do_stop();
    repeat (4) @(negedge clk);
    chk("busy_off", {15'h0, busy}, 16'h0);
  endtask

  // read n bytes from the model pointer; master ACKs all but the last
  task automatic read_seq(input int unsigned n);
    logic [7:0] d;
    exp_rd.push_back(mptr);
    send_byte(8'h85, 1'b1);
    for (int unsigned i = 0; i < n; i++) begin
      d = mbank[mptr];
      for (int j = 7; j >= 0; j--) clk_bit(1'b1, d[j]);
      if (i + 1 < n) begin
        mptr = mptr + 8'd1;
        exp_rd.push_back(mptr);
        clk_bit(1'b0, 1'b1);
      end else begin
        clk_bit(1'b1, 1'b1);
      end
    end
  endtask

  task automatic comb_read(input logic [7:0] p, input int unsigned n);
    do_start();
    send_byte(8'h84, 1'b1);
    send_byte(p, 1'b1);
    mptr = p;
    do_start();
    read_seq(n);
    do_stop();
  endtask

  task automatic wrong_addr(input logic [6:0] a, input logic rw);
    do_start();
    send_byte({a, rw}, 1'b0);
    chk("busy_wrong", {15'h0, busy}, 16'h0);
    send_byte(8'($urandom), 1'b0);
    do_stop();
  endtask

  logic [7:0]  v, p;
  logic [6:0]  a;
  int unsigned kind, n;

  initial begin
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      if (i == 32) v = 8'h3C;
      pl_addr = 8'(i); pl_data = v; pl_en = 1'b1;
      mbank[i] = v;
      @(negedge clk);
    end
    pl_en = 1'b0;
    @(negedge clk);
    chk("rst_sda_out", {15'h0, sda_out}, 16'h1);
    chk("rst_reg_addr", {8'h0, reg_addr}, 16'h0);
    chk("rst_reg_wdata", {8'h0, reg_wdata}, 16'h0);
    chk("rst_strobes", {14'h0, reg_wr, reg_rd}, 16'h0);
    chk("rst_busy_stop", {14'h0, busy, stop_det}, 16'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // write 0xA5, 0x5A at pointer 0x10
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    write_seq(8'h10, 2);

    // combined reads from 0x20 (0x3C), with and without master ACK
    comb_read(8'h20, 2);
    comb_read(8'h20, 1);

    // wrong address 0x90
    wrong_addr(7'h48, 1'b0);

    // pointer wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    write_seq(8'hFF, 2);

    // reset in the middle of a data byte
    do_start();
    send_byte(8'h84, 1'b1);
    send_byte(8'h30, 1'b1);
    for (int j = 0; j < 4; j++) clk_bit(1'($urandom), 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_sda_out", {15'h0, sda_out}, 16'h1);
    chk("midrst_busy", {15'h0, busy}, 16'h0);
    chk("midrst_ptr", {8'h0, reg_addr}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    mptr = 8'h00;
    for (int j = 0; j < 4; j++) clk_bit(1'($urandom), 1'b1);
    clk_bit(1'b1, 1'b1);
    send_byte(8'($urandom), 1'b0);
    do_start();
    send_byte(8'h84, 1'b1);
    do_stop();

    // STOP after four data bits
    p = 8'($urandom);
    do_start();
    send_byte(8'h84, 1'b1);
    send_byte(p, 1'b1);
    mptr = p;
    for (int j = 0; j < 4; j++) clk_bit(1'($urandom), 1'b1);
    do_stop();
    repeat (4) @(negedge clk);
    chk("stop_mid_busy", {15'h0, busy}, 16'h0);

    // pointer kept from the aborted write; plain read continues there
    do_start();
    read_seq(2);
    do_stop();

    // randomized traffic
    for (int unsigned it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      p = 8'($urandom);
      case (kind)
        0: begin
          for (int unsigned i = 0; i < n; i++) wbuf[i] = 8'($urandom);
          write_seq(p, n);
        end
        1: comb_read(p, n);
        2: begin
          a = 7'($urandom);
          if (a == 7'h42) a = 7'h43;
          wrong_addr(a, 1'($urandom));
        end
        default: begin
          do_start();
          read_seq(n);
          do_stop();
        end
      endcase
    end

    repeat (20) @(negedge clk);
    chk("wr_left", 16'(exp_wr.size()), 16'h0);
    chk("rd_left", 16'(exp_rd.size()), 16'h0);
    chk("sda_left", 16'(exp_sda.size()), 16'h0);
    chk("stop_count", 16'(stop_cnt), 16'(exp_stop));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
